// File: rtl/fb_page_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_page_arbiter
// Brief    : Single-port pixel RAM arbiter. Scanner reads take priority over
//            buffered host writes; front/back pages swap on a frame end.
// Revision : 1.0  initial release
// ============================================================================
module fb_page_arbiter #(
  parameter  int WR_FIFO_DEPTH = 4,
  parameter  int ADDR_W        = 11,
  parameter  int PIX_W         = 24,
  localparam int LVL_W         = $clog2(WR_FIFO_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_disp_req,
  input  logic [ADDR_W-1:0]    i_disp_addr,
  output logic [PIX_W-1:0]     o_disp_data0,
  output logic [PIX_W-1:0]     o_disp_data1,
  input  logic                 i_frame_end,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [5:0]           i_wr_x,
  input  logic [5:0]           i_wr_y,
  input  logic [PIX_W-1:0]     i_wr_rgb,
  input  logic                 i_swap_req,
  output logic                 o_swap_done,
  output logic                 o_front_page,
  output logic [LVL_W-1:0]     o_fifo_level,
  output logic                 o_ram_en,
  output logic                 o_ram_we,
  output logic [1:0]           o_ram_be,
  output logic [ADDR_W:0]      o_ram_addr,
  output logic [2*PIX_W-1:0]   o_ram_wdata,
  input  logic [2*PIX_W-1:0]   i_ram_rdata
);

  localparam int PTR_W   = $clog2(WR_FIFO_DEPTH);
  localparam int ENTRY_W = 12 + PIX_W;

  localparam logic [0:0] c_IDLE    = 1'b0;
  localparam logic [0:0] c_PENDING = 1'b1;

  logic [ENTRY_W-1:0] r_fifo_mem [WR_FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [LVL_W-1:0]   w_level_next;
  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic               r_front_page;
  logic               r_swap_done;
  logic               r_wr_ready;
  logic               w_push;
  logic               w_disp_grant;
  logic               w_wr_grant;
  logic               w_do_swap;
  logic [5:0]         w_head_x;
  logic [5:0]         w_head_y;
  logic [PIX_W-1:0]   w_head_rgb;
  logic [ADDR_W-1:0]  w_wr_word;

  // Reset also masks the RAM port so a held scanner request cannot leak out.
  assign w_disp_grant = i_disp_req & ~i_reset;
  assign w_wr_grant   = ~i_disp_req & (r_level != '0) & ~i_reset;
  assign w_push       = i_wr_valid & r_wr_ready;

  assign {w_head_y, w_head_x, w_head_rgb} = r_fifo_mem[r_rd_ptr];
  assign w_wr_word = ADDR_W'({w_head_y[4:0], w_head_x});

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_wr_grant})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  // A swap request seen together with a frame end still waits for the next one.
  always_comb begin
    w_state_next = r_state;
    w_do_swap    = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (i_swap_req) w_state_next = c_PENDING;
      end
      c_PENDING: begin
        if (i_frame_end && (r_level == '0) && !w_wr_grant) begin
          w_do_swap    = 1'b1;
          w_state_next = c_IDLE;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_state      <= c_IDLE;
      r_front_page <= 1'b0;
      r_swap_done  <= 1'b0;
      r_wr_ready   <= 1'b0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_wr_grant) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level     <= w_level_next;
      r_state     <= w_state_next;
      r_swap_done <= w_do_swap;
      if (w_do_swap) r_front_page <= ~r_front_page;
      r_wr_ready  <= (w_level_next < LVL_W'(WR_FIFO_DEPTH)) && (w_state_next == c_IDLE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {i_wr_y, i_wr_x, i_wr_rgb};
  end

  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_be    = 2'b00;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (w_disp_grant) begin
      o_ram_en   = 1'b1;
      o_ram_addr = {r_front_page, i_disp_addr};
    end else if (w_wr_grant) begin
      o_ram_en    = 1'b1;
      o_ram_we    = 1'b1;
      o_ram_be    = w_head_y[5] ? 2'b10 : 2'b01;
      o_ram_addr  = {~r_front_page, w_wr_word};
      o_ram_wdata = {w_head_rgb, w_head_rgb};
    end
  end

  assign o_disp_data0 = i_reset ? '0 : i_ram_rdata[PIX_W-1:0];
  assign o_disp_data1 = i_reset ? '0 : i_ram_rdata[2*PIX_W-1:PIX_W];
  assign o_wr_ready   = r_wr_ready;
  assign o_swap_done  = r_swap_done;
  assign o_front_page = r_front_page;
  assign o_fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fb_page_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_page_arbiter
// Brief    : Scoreboard bench for fb_page_arbiter with a behavioural pixel RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_page_arbiter;

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  be;
    logic [47:0] wdata;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        disp_req = 1'b0;
  logic [10:0] disp_addr = '0;
  logic [23:0] disp_data0, disp_data1;
  logic        frame_end = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_x = '0, wr_y = '0;
  logic [23:0] wr_rgb = '0;
  logic        swap_req = 1'b0;
  logic        swap_done, front_page;
  logic [2:0]  fifo_level;
  logic        ram_en, ram_we;
  logic [1:0]  ram_be;
  logic [11:0] ram_addr;
  logic [47:0] ram_wdata;
  logic [47:0] rdata = '0;
  logic        rd_tag = 1'b0;

  logic [47:0] mem [4096];
  wr_t         wq[$];
  logic [47:0] rq[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  fb_page_arbiter dut (
    .i_clk(clk), .i_reset(reset),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_data0(disp_data0), .o_disp_data1(disp_data1),
    .i_frame_end(frame_end),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_x(wr_x), .i_wr_y(wr_y), .i_wr_rgb(wr_rgb),
    .i_swap_req(swap_req), .o_swap_done(swap_done), .o_front_page(front_page),
    .o_fifo_level(fifo_level),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_be(ram_be),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(rdata)
  );

  // Pixel RAM: lane-enabled writes, 1-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_en && !ram_we) rdata <= mem[ram_addr];
    if (ram_en && ram_we) begin
      if (ram_be[0]) mem[ram_addr][23:0]  <= ram_wdata[23:0];
      if (ram_be[1]) mem[ram_addr][47:24] <= ram_wdata[47:24];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    wr_t         w;
    logic [47:0] e;
    logic        prev_tag;
    prev_tag = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_tag) begin
        if (rq.size() == 0) check("read_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          check("disp_data0", disp_data0, e[23:0]);
          check("disp_data1", disp_data1, e[47:24]);
        end
      end
      prev_tag = !reset && ram_en && !ram_we && rd_tag;
      if (!reset && ram_en && ram_we) begin
        if (wq.size() == 0) check("write_unexpected", 1, 0);
        else begin
          w = wq.pop_front();
          check("wr_addr", ram_addr, w.addr);
          check("wr_be", ram_be, w.be);
          check("wr_wdata", ram_wdata, w.wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [5:0] x, input logic [5:0] y, input logic [23:0] rgb,
                            input logic [11:0] eaddr, input logic [1:0] ebe);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_x = x; wr_y = y; wr_rgb = rgb;
    while (!wr_ready && n < 40) begin
      step();
      n++;
    end
    if (!wr_ready) check("wr_ready_timeout", 0, 1);
    else begin
      wq.push_back({eaddr, ebe, rgb, rgb});
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (fifo_level != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_level", fifo_level, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {front_page, swap_done, wr_ready, fifo_level}, 0);
    check("reset_ram", {ram_en, ram_we, ram_be, ram_addr}, 0);
    check("reset_wdata", ram_wdata, 0);
    check("reset_disp", {disp_data1, disp_data0}, 0);
    reset = 1'b0;
    step();
    check("ready_after_reset", wr_ready, 1);

    // Single write, bottom half, back page 1
    host_write(6'd5, 6'd40, 24'h123456, 12'hA05, 2'b10);
    #1;
    check("t2_level", fifo_level, 1);
    check("t2_en_we", {ram_en, ram_we}, 2'b11);
    check("t2_addr", ram_addr, 12'hA05);
    check("t2_be", ram_be, 2'b10);
    check("t2_wdata", ram_wdata, 48'h123456_123456);
    step();
    check("t2_idle", {ram_en, fifo_level}, 0);

    // Display holds the port; writes queue up
    disp_req = 1'b1; disp_addr = 11'h010;
    host_write(6'd5, 6'd8, 24'hABCDEF, 12'hA05, 2'b01);
    host_write(6'd0, 6'd0, 24'h111111, 12'h800, 2'b01);
    host_write(6'd63, 6'd63, 24'h222222, 12'hFFF, 2'b10);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_hold_we", ram_we, 0);
      check("t3_hold_level", fifo_level, 3);
      check("t3_disp_addr", ram_addr, 12'h010);
      step();
    end
    disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_drain_we", ram_we, 1);
      check("t3_drain_level", fifo_level, 3 - i);
      step();
    end
    check("t3_empty", {ram_en, fifo_level}, 0);

    // Fill the FIFO under display pressure
    disp_req = 1'b1;
    for (int i = 0; i < 4; i++)
      host_write(6'(10 + i), 6'd1, 24'h300000 + 24'(i), 12'h84A + 12'(i), 2'b01);
    check("t4_full_ready", wr_ready, 0);
    check("t4_full_level", fifo_level, 4);
    step();
    check("t4_hold_ready", wr_ready, 0);
    check("t4_hold_level", fifo_level, 4);
    disp_req = 1'b0;
    host_write(6'd14, 6'd1, 24'h300004, 12'h84E, 2'b01);
    check("t4_fifth_level", fifo_level, 3);
    wait_drain();

    // Swap requested with writes pending
    disp_req = 1'b1;
    host_write(6'd20, 6'd2, 24'h444444, 12'h894, 2'b01);
    host_write(6'd21, 6'd2, 24'h555555, 12'h895, 2'b01);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("t5_ready_pending", wr_ready, 0);
    check("t5_level", fifo_level, 2);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("t5_no_swap", {front_page, swap_done}, 2'b00);
    disp_req = 1'b0;
    wait_drain();
    check("t5_ready_still_low", wr_ready, 0);
    frame_end = 1'b1; disp_req = 1'b1; disp_addr = 11'h205;
    #1;
    check("t5_old_page_read", ram_addr, 12'h205);
    step();
    frame_end = 1'b0; disp_req = 1'b0;
    check("t5_swapped", {front_page, swap_done}, 2'b11);
    step();
    check("t5_done_pulse", {swap_done, wr_ready}, 2'b01);
    disp_req = 1'b1; disp_addr = 11'h205; rd_tag = 1'b1;
    rq.push_back({24'h123456, 24'hABCDEF});
    #1;
    check("t5_new_page_read", ram_addr, 12'hA05);
    step();
    disp_req = 1'b0; rd_tag = 1'b0;
    step();

    // Reset in the middle of a burst
    disp_req = 1'b1; disp_addr = 11'h010;
    host_write(6'd1, 6'd1, 24'h666666, 12'h041, 2'b01);
    host_write(6'd2, 6'd1, 24'h777777, 12'h042, 2'b01);
    #1;
    reset = 1'b1;
    wq.delete();
    #1;
    check("rst_state", {front_page, swap_done, wr_ready, fifo_level}, 0);
    check("rst_ram", {ram_en, ram_we, ram_be, ram_addr}, 0);
    check("rst_wdata", ram_wdata, 0);
    step();
    reset = 1'b0; disp_req = 1'b0;
    step();
    check("rst_after", {wr_ready, fifo_level, ram_en}, 5'b10000);
    host_write(6'd1, 6'd2, 24'h888888, 12'h881, 2'b01);
    #1;
    check("rst_page1_addr", ram_addr, 12'h881);
    step();

    // Swap request coincident with frame end
    swap_req = 1'b1; frame_end = 1'b1;
    step();
    swap_req = 1'b0; frame_end = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_pending", {front_page, wr_ready}, 2'b00);
      step();
    end
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("t6_swapped", {front_page, swap_done}, 2'b11);
    step();
    check("t6_idle", {swap_done, wr_ready}, 2'b01);

    step();
    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
